// File: rtl/iic_reg_slave_pkg.sv
// rtl/iic_reg_slave_pkg.sv - shared types and constants for the IIC register slave
// Purpose: FSM state enumeration, register window size and default device address.
// Ports: none (package).
package iic_reg_slave_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_ACK_DEV,
    S_ADDR_H,
    S_ACK_H,
    S_ADDR_L,
    S_ACK_L,
    S_WR_DATA,
    S_ACK_WR,
    S_RD_DATA,
    S_RD_ACK
  } state_e;

  localparam int         WIN_SIZE       = 16;
  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h36;

endpackage

// File: rtl/iic_reg_slave_line_filter.sv
// rtl/iic_reg_slave_line_filter.sv - synchroniser, glitch filter and edge flags for one IIC line
// Purpose: resynchronise an asynchronous bus line and accept a new level only after
//          FILT_LEN equal consecutive samples (FILT_LEN must be at least 2).
// Ports:   i_clk, i_rst (async, active-low), i_line (raw line),
//          o_level (filtered level), o_rise/o_fall (one-cycle flags, valid the
//          cycle before o_level takes the new value).
module iic_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0]          sync_q;
  logic [FILT_LEN-1:0] hist_q;
  logic                level_q;
  logic                level_d;

  // Released bus level is 1, so everything resets high.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q  <= 2'b11;
      hist_q  <= '1;
      level_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], i_line};
      hist_q  <= {hist_q[FILT_LEN-2:0], sync_q[1]};
      level_q <= level_d;
    end
  end

  always_comb begin
    level_d = level_q;
    if (&hist_q)       level_d = 1'b1;
    else if (~|hist_q) level_d = 1'b0;
  end

  assign o_level = level_q;
  assign o_rise  = level_d & ~level_q;
  assign o_fall  = ~level_d & level_q;

endmodule

// File: rtl/iic_reg_slave.sv
// rtl/iic_reg_slave.sv - IIC slave exposing a 16-entry register window
// Purpose: 7-bit addressed IIC slave with 16-bit register pointer, write strobes
//          and burst reads; entry 15 of the window reads back i_number.
// Ports:   i_clk, i_rst (async, active-low), i_iic_scl, i_iic_sda (bus inputs),
//          o_sda_dir/o_iic_sda (open-drain pull-down), i_number (read-only digit),
//          o_reg_wr/o_reg_addr/o_reg_data (write strobe + last write), o_busy.
module iic_reg_slave
  import iic_reg_slave_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter logic [15:0] REG_BASE   = 16'h0100,
  parameter int          FILT_LEN   = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_iic_scl,
  input  logic        i_iic_sda,
  output logic        o_sda_dir,
  output logic        o_iic_sda,
  input  logic [3:0]  i_number,
  output logic        o_reg_wr,
  output logic [15:0] o_reg_addr,
  output logic [7:0]  o_reg_data,
  output logic        o_busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  iic_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .i_clk(i_clk), .i_rst(i_rst), .i_line(i_iic_scl),
    .o_level(scl_lvl), .o_rise(scl_rise), .o_fall(scl_fall)
  );

  iic_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .i_clk(i_clk), .i_rst(i_rst), .i_line(i_iic_sda),
    .o_level(sda_lvl), .o_rise(sda_rise), .o_fall(sda_fall)
  );

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  addr_h_q, addr_h_d;
  logic        rw_q, rw_d;
  logic        sda_dir_q, sda_dir_d;
  logic        reg_wr_q, reg_wr_d;
  logic [15:0] reg_addr_q, reg_addr_d;
  logic [7:0]  reg_data_q, reg_data_d;
  logic        busy_q, busy_d;
  logic [7:0]  regfile_q [WIN_SIZE];
  logic [7:0]  regfile_d [WIN_SIZE];
  logic [7:0]  rd_nxt;

  wire start_det = sda_fall & scl_lvl;
  wire stop_det  = sda_rise & scl_lvl;

  // Read value at pointer p; i_number is sampled here, i.e. once per byte load.
  function automatic logic [7:0] rd_byte(input logic [15:0] p);
    if (p[15:4] != REG_BASE[15:4]) return 8'h00;
    if (p[3:0] == 4'hF)            return {4'h0, i_number};
    return regfile_q[p[3:0]];
  endfunction

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      addr_h_q   <= '0;
      rw_q       <= 1'b0;
      sda_dir_q  <= 1'b0;
      reg_wr_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < WIN_SIZE; i++) regfile_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      addr_h_q   <= addr_h_d;
      rw_q       <= rw_d;
      sda_dir_q  <= sda_dir_d;
      reg_wr_q   <= reg_wr_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      busy_q     <= busy_d;
      regfile_q  <= regfile_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    addr_h_d   = addr_h_q;
    rw_d       = rw_q;
    sda_dir_d  = sda_dir_q;
    reg_wr_d   = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    busy_d     = busy_q;
    regfile_d  = regfile_q;
    rd_nxt     = 8'h00;

    if (start_det) begin
      state_d   = S_DEV_ADDR;
      bit_cnt_d = '0;
      sda_dir_d = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      sda_dir_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_DEV_ADDR, S_ADDR_H, S_ADDR_L, S_WR_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            // Eighth SCL fall: byte complete, pull SDA low for the ACK slot.
            bit_cnt_d = '0;
            sda_dir_d = 1'b1;
            case (state_q)
              S_DEV_ADDR: begin
                if (shift_q[7:1] == SLAVE_ADDR) begin
                  rw_d    = shift_q[0];
                  state_d = S_ACK_DEV;
                end else begin
                  sda_dir_d = 1'b0;
                  state_d   = S_IDLE;
                end
              end
              S_ADDR_H: begin
                addr_h_d = shift_q;
                state_d  = S_ACK_H;
              end
              S_ADDR_L: begin
                ptr_d   = {addr_h_q, shift_q};
                state_d = S_ACK_L;
              end
              default: begin
                state_d    = S_ACK_WR;
                reg_wr_d   = 1'b1;
                reg_addr_d = ptr_q;
                reg_data_d = shift_q;
                if (ptr_q[15:4] == REG_BASE[15:4] && ptr_q[3:0] != 4'hF)
                  regfile_d[ptr_q[3:0]] = shift_q;
                ptr_d = ptr_q + 16'd1;
              end
            endcase
          end
        end
        S_ACK_DEV, S_ACK_H, S_ACK_L, S_ACK_WR: begin
          if (scl_fall) begin
            sda_dir_d = 1'b0;
            bit_cnt_d = '0;
            case (state_q)
              S_ACK_DEV: begin
                if (rw_q) begin
                  rd_nxt    = rd_byte(ptr_q);
                  shift_d   = rd_nxt;
                  sda_dir_d = ~rd_nxt[7];
                  state_d   = S_RD_DATA;
                end else begin
                  state_d = S_ADDR_H;
                end
              end
              S_ACK_H: state_d = S_ADDR_L;
              default: state_d = S_WR_DATA;
            endcase
          end
        end
        S_RD_DATA: begin
          // MSB was put on the bus at load; each fall presents the next bit.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_dir_d = 1'b0;
              bit_cnt_d = '0;
              state_d   = S_RD_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
              sda_dir_d = ~shift_q[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise && sda_lvl) begin
            state_d = S_IDLE;
          end else if (scl_fall) begin
            ptr_d     = ptr_q + 16'd1;
            rd_nxt    = rd_byte(ptr_q + 16'd1);
            shift_d   = rd_nxt;
            sda_dir_d = ~rd_nxt[7];
            bit_cnt_d = '0;
            state_d   = S_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sda_dir  = sda_dir_q;
  assign o_iic_sda  = 1'b0;
  assign o_reg_wr   = reg_wr_q;
  assign o_reg_addr = reg_addr_q;
  assign o_reg_data = reg_data_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_iic_reg_slave.sv
// tb/tb_iic_reg_slave.sv - self-checking bench for iic_reg_slave
module tb_iic_reg_slave;

  localparam int          Q    = 12;
  localparam logic [15:0] BASE = 16'h0100;

  logic        clk, rst_n, scl_m, sda_m;
  logic [3:0]  number;
  logic        sda_dir, iic_sda, reg_wr, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_data;
  wire         sda_bus = sda_m & (sda_dir ? iic_sda : 1'b1);

  iic_reg_slave dut (
    .i_clk(clk), .i_rst(rst_n), .i_iic_scl(scl_m), .i_iic_sda(sda_bus),
    .o_sda_dir(sda_dir), .o_iic_sda(iic_sda), .i_number(number),
    .o_reg_wr(reg_wr), .o_reg_addr(reg_addr), .o_reg_data(reg_data), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk, n_pass;
  logic [23:0] stb_q[$];
  int          dir_cnt, dir_bad;
  logic        dir_prev;
  logic        glitch_en;
  logic [7:0]  wbuf[8];
  logic [7:0]  mem[16];
  logic [15:0] mptr;

  always @(negedge clk) begin
    if (reg_wr) stb_q.push_back({reg_addr, reg_data});
    if (sda_dir) dir_cnt <= dir_cnt + 1;
    if (rst_n && sda_dir != dir_prev && scl_m) dir_bad <= dir_bad + 1;
    dir_prev <= sda_dir;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] ref_byte(input logic [15:0] p);
    int off;
    off = int'(p) - int'(BASE);
    if (off < 0 || off > 15) return 8'h00;
    if (off == 15) return {4'h0, number};
    return mem[off];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(Q); scl_m = 1'b1; tick(2*Q); scl_m = 1'b0;
      if (glitch_en && i == 4) begin
        tick(4); scl_m = 1'b1; tick(1); scl_m = 1'b0; tick(Q-5);
      end else tick(Q);
    end
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
    @(negedge clk) ack = sda_bus;
    tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(Q); scl_m = 1'b1; tick(Q);
      @(negedge clk) b[i] = sda_bus;
      tick(Q); scl_m = 1'b0; tick(Q);
    end
    sda_m = ~mack; tick(Q); scl_m = 1'b1; tick(2*Q); scl_m = 1'b0; tick(Q); sda_m = 1'b1;
  endtask

  task automatic addr_phase(input logic [15:0] a);
    logic ack;
    bus_start();
    write_byte(8'h6C, ack);   check_eq("ack_dev_w", ack, 0);
    write_byte(a[15:8], ack); check_eq("ack_addr_h", ack, 0);
    write_byte(a[7:0], ack);  check_eq("ack_addr_l", ack, 0);
    mptr = a;
  endtask

  task automatic xfer_write(input logic [15:0] a, input int n);
    logic        ack;
    logic [23:0] exp_q[$];
    int          lo;
    addr_phase(a);
    check_eq("busy_in_xfer", busy, 1);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], ack); check_eq("ack_data", ack, 0);
      exp_q.push_back({mptr, wbuf[i]});
      lo = int'(mptr) - int'(BASE);
      if (lo >= 0 && lo < 15) mem[lo] = wbuf[i];
      mptr = mptr + 16'd1;
    end
    bus_stop(); tick(2);
    check_eq("busy_after_stop", busy, 0);
    check_eq("stb_count", stb_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < stb_q.size(); i++) begin
      check_eq("stb_addr", stb_q[i][23:8], exp_q[i][23:8]);
      check_eq("stb_data", stb_q[i][7:0], exp_q[i][7:0]);
    end
    stb_q.delete();
  endtask

  task automatic xfer_read(input logic set_addr, input logic [15:0] a, input int n);
    logic       ack;
    logic [7:0] b, e;
    if (set_addr) addr_phase(a);
    bus_start();
    write_byte(8'h6D, ack); check_eq("ack_dev_r", ack, 0);
    for (int i = 0; i < n; i++) begin
      e = ref_byte(mptr);
      read_byte(i < n-1, b);
      check_eq("rd_data", b, e);
      if (i < n-1) mptr = mptr + 16'd1;
    end
    tick(2); check_eq("rel_after_nack", sda_dir, 0);
    bus_stop(); tick(2);
    check_eq("rd_no_stb", stb_q.size(), 0);
    stb_q.delete();
  endtask

  initial begin
    logic        ack;
    logic [15:0] a;
    int          n, d0;
    n_chk = 0; n_pass = 0; dir_cnt = 0; dir_bad = 0; dir_prev = 1'b0;
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; number = 4'h9; glitch_en = 1'b0;
    mptr = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    tick(5);
    @(negedge clk);
    check_eq("rst_dir", sda_dir, 0);
    check_eq("rst_sda", iic_sda, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr", reg_wr, 0);
    check_eq("rst_addr", reg_addr, 0);
    check_eq("rst_data", reg_data, 0);
    tick(1); rst_n = 1'b1; tick(5);

    // single write and read-back
    wbuf[0] = 8'hA5; xfer_write(16'h0103, 1);
    xfer_read(1'b1, 16'h0103, 1);

    // wrong device address
    d0 = dir_cnt;
    bus_start(); write_byte(8'h6A, ack); check_eq("nack_bad_dev", ack, 1);
    bus_stop(); tick(2);
    check_eq("bad_dev_no_drive", dir_cnt - d0, 0);
    check_eq("bad_dev_no_stb", stb_q.size(), 0);

    // window edge, number register and outside window
    number = 4'h7;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; xfer_write(16'h010E, 3);
    xfer_read(1'b1, 16'h010E, 3);

    // burst read of two bytes
    wbuf[0] = 8'h5A; wbuf[1] = 8'h3C; xfer_write(16'h0100, 2);
    xfer_read(1'b1, 16'h0100, 2);

    // pointer wrap
    wbuf[0] = 8'h44; wbuf[1] = 8'h55; xfer_write(16'hFFFF, 2);

    // SCL glitch ignored
    glitch_en = 1'b1; wbuf[0] = 8'hC3; xfer_write(16'h0105, 1); glitch_en = 1'b0;
    xfer_read(1'b1, 16'h0105, 1);

    // new START mid-byte
    addr_phase(16'h0100);
    sda_m = 1'b0;
    repeat (4) begin tick(Q); scl_m = 1'b1; tick(2*Q); scl_m = 1'b0; tick(Q); end
    wbuf[0] = 8'h77; xfer_write(16'h0107, 1);
    xfer_read(1'b1, 16'h0107, 1);

    // randomized transactions
    for (int t = 0; t < 10; t++) begin
      number = 4'($urandom);
      a = 16'h00FC + 16'($urandom_range(0, 24));
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
        xfer_write(a, n);
      end else xfer_read(1'b1, a, n);
    end
    xfer_read(1'b0, 16'h0000, 2);

    // reset in the middle of a read byte
    addr_phase(16'h0110);
    bus_start(); write_byte(8'h6D, ack); check_eq("ack_dev_r", ack, 0);
    sda_m = 1'b1;
    repeat (2) begin tick(Q); scl_m = 1'b1; tick(2*Q); scl_m = 1'b0; tick(Q); end
    @(negedge clk); check_eq("dir_before_rst", sda_dir, 1);
    #1 rst_n = 1'b0;
    #1 check_eq("dir_async_rst", sda_dir, 0);
    tick(3); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mptr = '0; stb_q.delete();
    scl_m = 1'b1; tick(Q);
    check_eq("busy_after_rst", busy, 0);
    xfer_read(1'b0, 16'h0000, 1);
    xfer_read(1'b1, 16'h0103, 1);

    check_eq("dir_change_scl_high", dir_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/iic_reg_slave.md
IIC_REG_SLAVE -- requirements
Module: iic_reg_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h36, 7-bit device address the block responds to.
REQ-002 Parameter REG_BASE, default 16'h0100, base of the 16-entry register window.
REQ-003 Parameter FILT_LEN, default 3, number of equal consecutive samples required to accept an SCL/SDA level change.
REQ-004 i_clk  in  1  system clock, 100 MHz; drives all state.
REQ-005 i_rst  in  1  reset; one clock; asynchronous, active-low.
REQ-006 i_iic_scl  in  1  IIC clock from master, asynchronous.
REQ-007 i_iic_sda  in  1  IIC data line as read back from the IOBUF.
REQ-008 o_sda_dir  out  1  1 = block drives SDA; driven value is always 0, matching the existing IOBUF hookup.
REQ-009 o_iic_sda  out  1  constant 0 while o_sda_dir=1; value is don't-care otherwise.
REQ-010 i_number  in  4  recognised digit, read-only at REG_BASE+15.
REQ-011 o_reg_wr  out  1  one-cycle strobe per accepted write byte.
REQ-012 o_reg_addr  out  16  full address of the last accepted write.
REQ-013 o_reg_data  out  8  data of the last accepted write.
REQ-014 o_busy  out  1  high from detected START until STOP.

Function
REQ-015 SCL and SDA pass through a 2-FF synchroniser and then the FILT_LEN glitch filter before any edge detection.
REQ-016 START = SDA falls while SCL is high; STOP = SDA rises while SCL is high; both are recognised in every state.
REQ-017 START in any state moves to DEV_ADDR and releases SDA; STOP in any state moves to IDLE and releases SDA.
REQ-018 States: IDLE, DEV_ADDR, ACK_DEV, ADDR_H, ACK_H, ADDR_L, ACK_L, WR_DATA, ACK_WR, RD_DATA, RD_ACK.
REQ-019 Data bits are sampled MSB first on SCL rising edges; SDA changes only within 2 clocks after an SCL falling edge.
REQ-020 ACK: after the 8th-bit SCL fall, assert o_sda_dir; release it on the 9th SCL fall.
REQ-021 On a device-address mismatch, send no ACK and return to IDLE.
REQ-022 A write (R/W=0) takes the sequence ADDR_H, ADDR_L, then repeated WR_DATA; every byte is ACKed.
REQ-023 Each accepted write byte pulses o_reg_wr exactly once, on the ACK_WR entry cycle, then increments the 16-bit pointer.
REQ-024 The pointer wraps from 16'hFFFF to 16'h0000.
REQ-025 A write inside the window (pointer[15:4]==REG_BASE[15:4]) updates regfile[pointer[3:0]], except at index 15.
REQ-026 Writes outside the window, and writes to index 15, are ACKed and strobed but the regfile does not change.
REQ-027 A read (R/W=1) starts at the current pointer and loads the shift register on ACK_DEV exit.
REQ-028 Read data: regfile entry in the window; {4'h0,i_number} at index 15; 8'h00 outside the window.
REQ-029 i_number is captured at the byte load, so it is stable for the whole byte.
REQ-030 In RD_DATA, drive SDA low for 0 bits and release it for 1 bits; release SDA before RD_ACK.
REQ-031 In RD_ACK, master ACK (SDA=0) increments the pointer and loads the next byte; master NACK goes to IDLE.
REQ-032 A read issued with no prior address phase since reset uses pointer 16'h0000.

Reset
REQ-033 While i_rst=0, the state is IDLE, o_sda_dir=0, o_iic_sda=0, o_reg_wr=0, o_reg_addr=0, o_reg_data=0, o_busy=0.
REQ-034 While i_rst=0, the pointer is 0, all regfile entries are 8'h00, and the filters hold the released (1) level.
REQ-035 Reset asserted mid-transfer releases SDA asynchronously within the same cycle.
REQ-036 After reset, the block ignores all bus activity until the next START.

Structure
REQ-037 A shared package holds the state enumeration, the 16-entry window size constant and the default SLAVE_ADDR.
REQ-038 Sub-module iic_line_filter (synchroniser, glitch filter, rise/fall flags) is instantiated twice, once for SCL and once for SDA.

Verification
REQ-039 Write 0x36/W, 0x01, 0x03, data 0xA5 -> four ACKs; one o_reg_wr with addr 16'h0103, data 8'hA5; regfile[3]=0xA5.
REQ-040 Write to 0x010E, 0x010F, 0x0110 with data 0x11, 0x22, 0x33, then read back 3 bytes -> returns 0x11, {4'h0,i_number}, 0x00; three strobes.
REQ-041 Address 0x35/W -> no ACK; SDA never driven; state returns to IDLE; no strobe.
REQ-042 Burst read of 2 bytes from 0x0100 holding 0x5A, 0x3C, master NACK after byte 2 -> SDA bits 01011010 then 00111100; SDA released after the NACK.
REQ-043 Write to address 0xFFFF then a second data byte -> second strobe reports addr 16'h0000.
REQ-044 Cases: 1-clock SCL glitch -> ignored; reset pulsed during read -> SDA released at once; new START mid-byte -> resync to DEV_ADDR.
